// File: rtl/audio_dac_serializer.sv
// I2S transmitter for packed stereo samples {left[31:16], right[15:0]}.
// Drives BCLK/LRCK as link master, with a one-deep valid/ready holding register toward upstream.
module audio_dac_serializer #(
  parameter int BCLK_HALF = 8,
  parameter int SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inputAudio,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        bclk,
  output logic        lrck,
  output logic        dacdat,
  output logic        underrun
);

  localparam int DivW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int CntW = $clog2(2 * SLOT_BITS);
  localparam logic [DivW-1:0] DivMax  = DivW'(BCLK_HALF - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(2 * SLOT_BITS - 1);
  localparam logic [CntW-1:0] SlotLen = CntW'(SLOT_BITS);

  logic [DivW-1:0] div_q, div_d;
  logic            bclk_q, bclk_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic            lrck_q, lrck_d;
  logic            dacdat_q, dacdat_d;
  logic [31:0]     shift_q, shift_d;
  logic [31:0]     hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            ready_q, ready_d;
  logic            underrun_q, underrun_d;

  logic            div_tc;
  logic            fall;
  logic [CntW-1:0] bit_next;
  logic            right_slot;
  logic [CntW-1:0] slot_pos;
  logic            frame_start;
  logic            xfer;

  always_comb begin
    div_d       = div_q;
    bclk_d      = bclk_q;
    bit_cnt_d   = bit_cnt_q;
    lrck_d      = lrck_q;
    dacdat_d    = dacdat_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    div_tc      = (div_q == DivMax);
    fall        = div_tc && bclk_q;
    bit_next    = (bit_cnt_q == CntMax) ? '0 : bit_cnt_q + CntW'(1);
    right_slot  = (bit_next >= SlotLen);
    slot_pos    = right_slot ? bit_next - SlotLen : bit_next;
    frame_start = fall && (bit_next == '0);
    xfer        = sample_valid && ready_q;

    div_d  = div_tc ? '0 : div_q + DivW'(1);
    bclk_d = div_tc ? ~bclk_q : bclk_q;

    // The shifter streams left MSB-first, after which the right channel sits in the top half.
    if (fall) begin
      bit_cnt_d = bit_next;
      lrck_d    = right_slot;
      dacdat_d  = 1'b0;
      if (frame_start) begin
        shift_d = hold_full_q ? hold_q : '0;
      end else if (slot_pos >= CntW'(1) && slot_pos <= CntW'(16)) begin
        dacdat_d = shift_q[31];
        shift_d  = {shift_q[30:0], 1'b0};
      end
    end

    // A sample accepted on a frame-start edge waits for the next frame rather than bypassing.
    if (frame_start && hold_full_q) begin
      hold_full_d = 1'b0;
    end
    if (xfer) begin
      hold_d      = inputAudio;
      hold_full_d = 1'b1;
    end

    ready_d    = !hold_full_d;
    underrun_d = frame_start && !hold_full_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      bclk_q      <= 1'b0;
      bit_cnt_q   <= CntMax;
      lrck_q      <= 1'b1;
      dacdat_q    <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      underrun_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      bit_cnt_q   <= bit_cnt_d;
      lrck_q      <= lrck_d;
      dacdat_q    <= dacdat_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      underrun_q  <= underrun_d;
    end
  end

  assign sample_ready = ready_q;
  assign bclk         = bclk_q;
  assign lrck         = lrck_q;
  assign dacdat       = dacdat_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: a default instance driven through several scenarios and a
// small BCLK_HALF=2 / SLOT_BITS=17 instance; expected serial bits flow through per-instance queues.
module tb_audio_dac_serializer;

  localparam int BhA = 8;
  localparam int SbA = 32;
  localparam int FrA = 2 * SbA * 2 * BhA;
  localparam int BhB = 2;
  localparam int SbB = 17;
  localparam int FrB = 2 * SbB * 2 * BhB;

  logic        clock = 1'b0;
  logic        reset, resetB;
  logic        validA, validB;
  logic [31:0] audioA, audioB;
  logic        readyA, bclkA, lrckA, datA, undA;
  logic        readyB, bclkB, lrckB, datB, undB;

  int passCount  = 0;
  int totalCount = 0;

  logic [1:0]  bitQA[$];
  logic [1:0]  bitQB[$];

  int          mCyc;
  logic        mFull, mXfer, expUnd;
  logic [31:0] mHold;

  logic prevBclkA, prevLrckA, prevDatA, haveRiseA, haveFallA;
  int   sinceRiseA, sinceFallA;
  logic prevBclkB, prevLrckB, haveRiseB, haveFallB;
  int   sinceRiseB, sinceFallB;

  always #5 clock = ~clock;

  audio_dac_serializer dutA (
    .clk(clock), .rst(reset), .inputAudio(audioA), .sample_valid(validA),
    .sample_ready(readyA), .bclk(bclkA), .lrck(lrckA), .dacdat(datA), .underrun(undA)
  );

  audio_dac_serializer #(.BCLK_HALF(BhB), .SLOT_BITS(SbB)) dutB (
    .clk(clock), .rst(resetB), .inputAudio(audioB), .sample_valid(validB),
    .sample_ready(readyB), .bclk(bclkB), .lrck(lrckB), .dacdat(datB), .underrun(undB)
  );

  // Expected {lrck, dacdat} seen at the BCLK rise that follows bit n of a frame.
  function automatic logic [1:0] expBit(input logic [31:0] d, input int n, input int sb);
    logic        right;
    int          k;
    logic [15:0] ch;
    right = (n >= sb);
    k     = right ? n - sb : n;
    ch    = right ? d[15:0] : d[31:16];
    return {right, (k >= 1 && k <= 16) ? ch[16-k] : 1'b0};
  endfunction

  function automatic logic isFrameEdge(input int t, input int bh, input int fr);
    return (t >= 2 * bh) && ((t - 2 * bh) % fr == 0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d);
    validA = v;
    audioA = d;
  endtask

  task automatic stepClk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Returns at the negedge just before a frame-start edge of instance A.
  task automatic waitFrameEdge();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!isFrameEdge(mCyc + 1, BhA, FrA) && n < FrA + 4);
  endtask

  task automatic pushFrameB(input logic [31:0] d);
    for (int n = 0; n < 2 * SbB; n++) bitQB.push_back(expBit(d, n, SbB));
  endtask

  // Transaction-level model of instance A: frame starts fall at fixed cycle offsets from reset release.
  always @(posedge clock) begin
    if (reset) begin
      mCyc   <= 0;
      mFull  <= 1'b0;
      mHold  <= '0;
      mXfer  <= 1'b0;
      expUnd <= 1'b0;
      bitQA.delete();
    end else begin
      mCyc   <= mCyc + 1;
      mXfer  <= validA && !mFull;
      expUnd <= isFrameEdge(mCyc + 1, BhA, FrA) && !mFull;
      if (mCyc == 0) bitQA.push_back(2'b10);
      if (isFrameEdge(mCyc + 1, BhA, FrA)) begin
        for (int n = 0; n < 2 * SbA; n++) bitQA.push_back(expBit(mFull ? mHold : 32'h0, n, SbA));
      end
      if (validA && !mFull) begin
        mFull <= 1'b1;
        mHold <= audioA;
      end else if (isFrameEdge(mCyc + 1, BhA, FrA) && mFull) begin
        mFull <= 1'b0;
      end
    end
  end

  // Instance A monitor: handshake and underrun every clk, serial bits at each BCLK rise.
  always @(negedge clock) begin
    if (reset) begin
      prevBclkA  <= 1'b0;
      prevLrckA  <= 1'b1;
      prevDatA   <= 1'b0;
      haveRiseA  <= 1'b0;
      haveFallA  <= 1'b0;
      sinceRiseA <= 0;
      sinceFallA <= 0;
    end else begin
      checkOutput("readyA", 32'(readyA), 32'(!mFull));
      checkOutput("underrunA", 32'(undA), 32'(expUnd));
      checkOutput("datOnFallA", 32'((datA === prevDatA) || (prevBclkA && !bclkA)), 32'd1);
      if (!prevBclkA && bclkA) begin
        if (haveRiseA) checkOutput("bclkPeriodA", 32'(sinceRiseA + 1), 32'(2 * BhA));
        checkOutput("bitQueueA", 32'(bitQA.size() > 0), 32'd1);
        if (bitQA.size() > 0) checkOutput("serialA", 32'({lrckA, datA}), 32'(bitQA.pop_front()));
        haveRiseA  <= 1'b1;
        sinceRiseA <= 0;
      end else begin
        sinceRiseA <= sinceRiseA + 1;
      end
      if (prevLrckA && !lrckA) begin
        if (haveFallA) checkOutput("frameLenA", 32'(sinceFallA + 1), 32'(FrA));
        haveFallA  <= 1'b1;
        sinceFallA <= 0;
      end else begin
        sinceFallA <= sinceFallA + 1;
      end
      prevBclkA <= bclkA;
      prevLrckA <= lrckA;
      prevDatA  <= datA;
    end
  end

  // Instance B monitor: timing of the short configuration plus the queued frames.
  always @(negedge clock) begin
    if (resetB) begin
      prevBclkB  <= 1'b0;
      prevLrckB  <= 1'b1;
      haveRiseB  <= 1'b0;
      haveFallB  <= 1'b0;
      sinceRiseB <= 0;
      sinceFallB <= 0;
    end else begin
      if (!prevBclkB && bclkB) begin
        if (haveRiseB) checkOutput("bclkPeriodB", 32'(sinceRiseB + 1), 32'(2 * BhB));
        if (bitQB.size() > 0) checkOutput("serialB", 32'({lrckB, datB}), 32'(bitQB.pop_front()));
        haveRiseB  <= 1'b1;
        sinceRiseB <= 0;
      end else begin
        sinceRiseB <= sinceRiseB + 1;
      end
      if (prevLrckB && !lrckB) begin
        if (haveFallB) checkOutput("frameLenB", 32'(sinceFallB + 1), 32'(FrB));
        haveFallB  <= 1'b1;
        sinceFallB <= 0;
      end else begin
        sinceFallB <= sinceFallB + 1;
      end
      prevBclkB <= bclkB;
      prevLrckB <= lrckB;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset  = 1'b1;
    resetB = 1'b1;
    validB = 1'b0;
    audioB = '0;
    applyStimulus(1'b0, 32'h0);
    stepClk(3);
    checkOutput("resetValuesA", 32'({bclkA, lrckA, datA, readyA, undA}), 32'b01010);
    checkOutput("resetValuesB", 32'({bclkB, lrckB, datB, readyB, undB}), 32'b01010);

    // Short configuration: one sample then two idle frames, no padding bits in a 17-bit slot.
    resetB = 1'b0;
    validB = 1'b1;
    audioB = 32'hC3A5_5A3C;
    bitQB.push_back(2'b10);
    pushFrameB(32'hC3A5_5A3C);
    pushFrameB(32'h0);
    pushFrameB(32'h0);
    stepClk(1);
    validB = 1'b0;
    stepClk(430);
    checkOutput("queueDrainB", 32'(bitQB.size()), 32'd0);
    resetB = 1'b1;

    // Idle link: all-zero frames, underrun once per frame starting 16 clk after release.
    reset = 1'b0;
    stepClk(2 * FrA + 2 * BhA + 40);

    // Single sample accepted on the first clk after release.
    reset = 1'b1;
    stepClk(2);
    applyStimulus(1'b1, 32'h8001_7FFF);
    reset = 1'b0;
    stepClk(1);
    applyStimulus(1'b0, 32'h0);
    stepClk(2 * FrA + 40);

    // Upstream streams incrementing samples with valid held high.
    applyStimulus(1'b1, 32'h0001_0002);
    repeat (4 * FrA) begin
      @(negedge clock);
      if (mXfer) audioA = audioA + 32'h0002_0002;
    end

    // Transfer coincides with a frame start while the hold register is empty.
    applyStimulus(1'b0, 32'h0);
    waitFrameEdge();
    stepClk(1);
    waitFrameEdge();
    applyStimulus(1'b1, 32'hA5C3_3C5A);
    stepClk(1);
    applyStimulus(1'b0, 32'h0);
    stepClk(2 * FrA + 40);

    // One-clk reset in the middle of the left slot while all-ones samples are streaming.
    applyStimulus(1'b1, 32'hFFFF_FFFF);
    waitFrameEdge();
    stepClk(1 + 2 * BhA * 8);
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0);
    stepClk(1);
    checkOutput("midFrameReset", 32'({bclkA, lrckA, datA, readyA, undA}), 32'b01010);
    reset = 1'b0;
    stepClk(2 * FrA + 40);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
- Transmit-side counterpart of the audio sample bus.
- Accepts packed stereo samples {left[31:16], right[15:0]}, the same 32-bit format the level meter consumes.
- Serializes each sample onto an I2S link to the board codec DAC, acting as bit-clock and LR-clock master.
- Sits between the filter chain output and the codec pins; one-deep holding register with valid/ready handshake toward upstream.

Parameters:
- BCLK_HALF, 8: clk cycles per half BCLK period (BCLK = clk/(2*BCLK_HALF)); must be >= 2.
- SLOT_BITS, 32: BCLK periods per channel slot; must be >= 17 (16 data bits plus the 1-bit I2S delay).

Ports:
- clk  input  1  system clock; only clock in the block.
- rst  input  1  synchronous, active-high reset.
- inputAudio  input  32  packed sample, left in [31:16], right in [15:0], two's complement.
- sample_valid  input  1  upstream asserts when inputAudio holds a sample.
- sample_ready  output  1  high when the holding register is empty.
- bclk  output  1  I2S bit clock.
- lrck  output  1  0 = left slot, 1 = right slot.
- dacdat  output  1  serial data; changes only on BCLK falling edges.
- underrun  output  1  one-clk pulse when a frame starts with no sample held.

Behaviour:
- Reset values: bclk=0, lrck=1, dacdat=0, sample_ready=1, underrun=0. Internally: hold empty, bit_cnt=2*SLOT_BITS-1, div_cnt=0, shift register=0.
- Reset mid-frame aborts the frame immediately. Every output takes its reset value on the next edge, and any held sample is discarded.
- Divider: div_cnt counts 0..BCLK_HALF-1. At terminal count it wraps and bclk toggles.
- A toggle 1->0 is a "fall event". All serial state changes only on fall events.
- Fall event:
  - bit_cnt increments, wrapping 2*SLOT_BITS-1 -> 0.
  - lrck <= (new bit_cnt >= SLOT_BITS).
  - Slot position k = new bit_cnt mod SLOT_BITS.
  - dacdat <= channel bit [16-k] for k = 1..16, MSB first. dacdat = 0 for k = 0 and for k > 16 (I2S one-bit delay, zero padding).
- Frame start is the fall event where bit_cnt wraps to 0.
  - If hold is full: shift register <= hold, hold is emptied.
  - If hold is empty: shift register <= 0 and underrun pulses high for exactly that clk.
- First frame start occurs 2*BCLK_HALF clk cycles after rst deasserts; the first data bit (left MSB) follows one BCLK later.
- Handshake:
  - A transfer occurs on a clk edge with sample_valid && sample_ready. hold <= inputAudio, and sample_ready drops the next cycle.
  - sample_ready = !hold_full, registered.
  - Upstream may hold sample_valid high indefinitely; at most one sample is accepted per frame once hold is full.
- Simultaneous transfer and frame start with hold empty:
  - The frame loads zero and flags underrun.
  - The newly accepted sample stays in hold for the following frame; it does not bypass.
- Simultaneous transfer and frame start with hold full cannot occur, because sample_ready = 0.
- Widths and data path:
  - Data is passed bit-exact; no arithmetic, no sign handling.
  - Left channel transmitted in the lrck=0 slot, right in the lrck=1 slot.
- Frame length is 2*SLOT_BITS*2*BCLK_HALF clk cycles (1024 at defaults, about 48.8 kHz fs at 50 MHz).

Test Plan:
- Reset, no valid -> bclk period 16 clk; lrck toggles every 32 BCLK; dacdat constant 0; underrun pulses once per 1024 clk, first at clk 16 after reset release.
- Single sample 32'h8001_7FFF accepted at cycle 1 -> left slot bits after delay 1000_0000_0000_0001, right slot bits 0111_1111_1111_1111; bit 0 of each slot and bits 17..31 are 0; no underrun for that frame.
- Continuous valid with incrementing samples 32'h0001_0002, 32'h0003_0004, ... -> sample_ready high for 1 clk after each frame start; exactly one transfer per 1024 clk; decoded frames match the input order with no drops or repeats.
- Transfer on the same clk as a frame start with hold empty -> that frame is all zeros with underrun=1; the next frame carries the sample.
- Assert rst for 1 clk mid-left-slot while transmitting 32'hFFFF_FFFF -> next clk shows bclk=0, lrck=1, dacdat=0, sample_ready=1; the held sample is lost; the first frame after release is an underrun frame.
- Override BCLK_HALF=2, SLOT_BITS=17 -> bclk period 4 clk, frame 136 clk, left MSB on the first BCLK after the lrck fall, and no padding bits.
